// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a four-state debounce FSM with edge pulses
// and a saturating count of rejected candidate level changes.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_in,
    input  logic       clr_glitch,
    output logic       data_out,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             sync1_r;
    logic             sync2_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             data_r;
    logic             rise_r;
    logic             fall_r;
    logic             busy_r;
    logic [7:0]       glitch_r;
    logic             abort_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    assign data_out   = data_r;
    assign rise       = rise_r;
    assign fall       = fall_r;
    assign busy       = busy_r;
    assign glitch_cnt = glitch_r;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw_in;
            sync2_r <= sync1_r;
        end
    end

    // A candidate change is aborted when the synchronized level reverts mid-check.
    always_comb begin
        abort_s = 1'b0;
        case (state_r)
            CHECK_HIGH: abort_s = ~sync2_r;
            CHECK_LOW:  abort_s = sync2_r;
            default:    abort_s = 1'b0;
        endcase
    end

    // Debounce FSM; every output is registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= STABLE_LOW;
            cnt_r    <= CNT_ZERO;
            data_r   <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
            busy_r   <= 1'b0;
            glitch_r <= 8'd0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state_r)
                STABLE_LOW: begin
                    if (sync2_r) begin
                        state_r <= CHECK_HIGH;
                        cnt_r   <= CNT_ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end
                end
                CHECK_HIGH: begin
                    if (!sync2_r) begin
                        state_r <= STABLE_LOW;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= STABLE_HIGH;
                        cnt_r   <= CNT_ZERO;
                        data_r  <= 1'b1;
                        rise_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        busy_r  <= 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2_r) begin
                        state_r <= CHECK_LOW;
                        cnt_r   <= CNT_ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end
                end
                CHECK_LOW: begin
                    if (sync2_r) begin
                        state_r <= STABLE_HIGH;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= STABLE_LOW;
                        cnt_r   <= CNT_ZERO;
                        data_r  <= 1'b0;
                        fall_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= STABLE_LOW;
                    cnt_r   <= CNT_ZERO;
                    data_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
            // Clear takes priority over a same-cycle abort.
            if (clr_glitch) begin
                glitch_r <= 8'd0;
            end else if (abort_s) begin
                glitch_r <= sat_inc8(glitch_r);
            end else begin
                glitch_r <= glitch_r;
            end
        end
    end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive synchronized samples required to accept a level change; legal range 2..255.
REQ-002 Parameter: CNT_W, default 8, width of the internal debounce counter; SHALL be >= clog2(DEBOUNCE_CYCLES).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; 0 resets the block immediately, independent of clk.
REQ-005 Port: raw_in  input  1  asynchronous, bouncy level (switch/pin); no timing relation to clk.
REQ-006 Port: clr_glitch  input  1  synchronous clear of glitch_cnt, sampled on clk.
REQ-007 Port: data_out  output  1  debounced, synchronized level; drives the data input of the downstream 1-bit D flip-flop.
REQ-008 Port: rise  output  1  one-cycle pulse on accepted 0->1 change of data_out.
REQ-009 Port: fall  output  1  one-cycle pulse on accepted 1->0 change of data_out.
REQ-010 Port: busy  output  1  high while a candidate level change is being qualified.
REQ-011 Port: glitch_cnt  output  8  saturating count of rejected (aborted) candidate changes.

Function
REQ-012 raw_in SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 is used by the rest of the block.
REQ-013 FSM states SHALL be STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW; all outputs registered.
REQ-014 STABLE_LOW: sync2=1 -> CHECK_HIGH, cnt=1; else stay, cnt=0.
REQ-015 CHECK_HIGH: sync2=0 -> STABLE_LOW, cnt=0, glitch abort; sync2=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_HIGH, data_out=1, rise=1, cnt=0; else cnt=cnt+1.
REQ-016 STABLE_HIGH / CHECK_LOW SHALL mirror REQ-014/015 with polarity inverted; acceptance sets data_out=0 and fall=1.
REQ-017 Latency: with raw_in steady from the first clk edge that samples it as 1 (edge 1), data_out SHALL rise at edge DEBOUNCE_CYCLES+2; same for falling.
REQ-018 rise and fall SHALL be high for exactly one cycle, coincident with the cycle data_out first shows the new level; never both high.
REQ-019 busy SHALL be 1 exactly when state is CHECK_HIGH or CHECK_LOW.
REQ-020 Each glitch abort SHALL increment glitch_cnt by 1; glitch_cnt SHALL saturate at 255 (no wrap).
REQ-021 clr_glitch=1 SHALL set glitch_cnt to 0 on the next edge; if an abort occurs the same cycle, clear wins (result 0).
REQ-022 A pulse on sync2 shorter than DEBOUNCE_CYCLES samples SHALL not change data_out and SHALL produce no rise/fall.
REQ-023 cnt SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-024 While reset=0: sync1=sync2=0, state=STABLE_LOW, cnt=0, data_out=0, rise=0, fall=0, busy=0, glitch_cnt=0.
REQ-025 Reset asserted mid-qualification SHALL abort without counting a glitch and without any rise/fall pulse.
REQ-026 On reset release with raw_in held 1, data_out SHALL rise per REQ-017 with a single rise pulse.

Verification
REQ-027 DEBOUNCE_CYCLES=4, reset released, raw_in 0->1 held -> data_out=1 and rise=1 at edge 6 after first high sample; rise=0 at edge 7; busy=1 edges 3-5.
REQ-028 raw_in high for 2 cycles then low -> data_out stays 0, no rise, glitch_cnt=1, busy returns to 0.
REQ-029 From data_out=1, raw_in 1->0 held -> data_out=0 and fall=1 at edge 6; fall one cycle only.
REQ-030 300 short glitches -> glitch_cnt=255 (saturated); clr_glitch pulsed together with one further abort -> glitch_cnt=0.
REQ-031 reset=0 asserted asynchronously during CHECK_HIGH (between edges) -> all outputs 0 immediately; after release with raw_in=1, exactly one rise at edge 6.
REQ-032 raw_in bouncing (1,0,1,1,0,1,1,1,1 ...) -> data_out rises only after 4 consecutive high sync2 samples; glitch_cnt equals number of aborted checks (2).
